ahb_manager_arbiter: RTL and testbench
======================================

# ahb_manager_arbiter

Two-port AHB-Lite manager front end that shares the single AHB-Lite manager path between the instruction-fetch requester (port 0) and the data requester (port 1). Each requester uses a simple req/ack interface. The arbiter picks one requester by round-robin, issues a single non-burst AHB-Lite transfer, waits out slave wait states and error responses, and returns read data and status to the granted requester. It sits between the core's memory ports and the bus mux/decoder, whose unmapped region is served by the default satellite (always ready, OKAY, zero data).

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  clock; all logic on rising edge
- nrst  in  1  reset, synchronous, active-low
- req[1:0]  in  2  per-requester transfer request; held with fields stable until matching ack
- addr0/addr1  in  ADDR_W  per-requester byte address
- write0/write1  in  1  1 = write
- size0/size1  in  3  HSIZE encoding (0 byte, 1 half, 2 word)
- wdata0/wdata1  in  DATA_W  write data
- ack[1:0]  out  2  one-cycle completion pulse to the granted requester
- rdata  out  DATA_W  read data, valid with ack
- err  out  1  1 = transfer ended with ERROR response, valid with ack
- haddr  out  ADDR_W  AHB address
- htrans  out  2  IDLE (00) or NONSEQ (10) only
- hwrite  out  1; hsize  out  3; hburst  out  3  fixed SINGLE (000)
- hwdata  out  DATA_W  write data, driven in data phase
- hrdata  in  DATA_W; hready  in  1; hresp  in  1  from the bus mux

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE: htrans = IDLE. If any req is set, grant = round-robin choice and go to ADDR.
- Round-robin: a single-bit last_grant register. On a tie, the requester that is not last_grant wins. A lone requester always wins. last_grant updates on entry to ADDR.
- ADDR: drive htrans = NONSEQ, plus haddr/hwrite/hsize from the granted requester. Stay while hready = 0 (a previous slave is stalling). Go to DATA when hready = 1.
- DATA: drive htrans = IDLE and hwdata = granted wdata. Wait while hready = 0. When hready = 1:
  - ack[grant] = 1, rdata = hrdata, err = hresp.
  - Return to IDLE.
- Error response: hresp = 1 with hready = 0 is the first error cycle; keep waiting. The ack is given on the second cycle with err = 1. Requester req is not re-evaluated until IDLE.
- A request deasserted before its ack is a protocol violation with undefined behaviour. The bench asserts against it.
- Grant is never changed outside IDLE.

## Timing
- Zero-wait transfer: req seen in IDLE at cycle 0, NONSEQ at cycle 1, ack at cycle 2. Minimum 3 cycles per transfer. Each wait state adds 1 cycle.
- ack, rdata and err are combinational from hready/hrdata/hresp in DATA. All other outputs depend only on registered state and the granted requester's inputs.
- Outputs when not in DATA with hready = 1: ack = 0, err = 0, rdata = 0.
- Outputs outside ADDR: haddr = 0, hwrite = 0, hsize = 0.
- Reset (nrst = 0 at a clock edge, any state, including mid-transfer): state = IDLE, last_grant = 1 (port 0 wins the first tie), grant = 0, htrans = IDLE. No ack is produced for an aborted transfer.

## Structure
- Add to common_types_pkg:
  - arb_state_t enum {IDLE, ADDR, DATA}.
  - HTRANS_IDLE, HTRANS_NONSEQ, HBURST_SINGLE constants.
  - HSIZE_BYTE, HSIZE_HALF, HSIZE_WORD constants.
- One sub-module: rr_arbiter2. Inputs clk, nrst, req[1:0], update. Outputs grant and valid. It holds the last_grant register.
- Top-level module: FSM plus the per-requester field mux.

## Test plan
- Single read on port 1: addr1 = 0x2000_0010, satellite returns 0xDEAD_BEEF with zero wait → NONSEQ at cycle 1, ack[1] at cycle 2, rdata = 0xDEAD_BEEF, err = 0.
- Both ports request every cycle for 6 transfers → grants alternate 0,1,0,1,0,1. The first grant goes to port 0.
- Write on port 0 (0x0000_0100, data 0x1234_5678, size word), hready low for 3 data-phase cycles → hwdata stable for 4 cycles, ack[0] on the 4th cycle.
- Unmapped address routed to the default satellite → ack at cycle 2, rdata = 0, err = 0. Two-cycle ERROR injection (hresp = 1/hready = 0, then hresp = 1/hready = 1) → ack with err = 1 one cycle later than an OKAY response.
- nrst low during DATA with hready held low → next cycle state IDLE, htrans = IDLE, no ack. A port 0 request with both ports requesting after reset wins first.

Source files
------------

// File: rtl/ahb_manager_arbiter_pkg.sv
// Shared types and AHB-Lite encodings for the two-port manager arbiter.
package ahb_manager_arbiter_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

endpackage

// File: rtl/ahb_manager_arbiter_rr.sv
// Two-way round-robin picker; last_grant resets to 1 so port 0 wins the first tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       nrst,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant,
    output logic       valid
);

    logic last_grant;

    always_comb begin
        grant = 1'b0;
        if (req == 2'b11)
            grant = ~last_grant;
        else if (req[1])
            grant = 1'b1;
    end

    assign valid = |req;

    always_ff @(posedge clk) begin
        if (!nrst)
            last_grant <= 1'b1;
        else if (update)
            last_grant <= grant;
    end

endmodule

// File: rtl/ahb_manager_arbiter.sv
// Shares one AHB-Lite manager path between fetch (port 0) and data (port 1)
// requesters, one SINGLE transfer at a time.
module ahb_manager_arbiter
    import ahb_manager_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              write0,
    input  logic              write1,
    input  logic [2:0]        size0,
    input  logic [2:0]        size1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hready,
    input  logic              hresp
);

    arb_state_t state;
    logic       grant;
    logic       arb_grant;
    logic       arb_valid;
    logic       arb_update;
    logic       done;

    logic [NUM_REQ-1:0][ADDR_W-1:0] addr_v;
    logic [NUM_REQ-1:0]             write_v;
    logic [NUM_REQ-1:0][2:0]        size_v;
    logic [NUM_REQ-1:0][DATA_W-1:0] wdata_v;

    assign addr_v  = {addr1, addr0};
    assign write_v = {write1, write0};
    assign size_v  = {size1, size0};
    assign wdata_v = {wdata1, wdata0};

    // Arbitration history only advances when a grant is actually taken.
    assign arb_update = (state == IDLE) && arb_valid;

    rr_arbiter2 u_rr (
        .clk    (clk),
        .nrst   (nrst),
        .req    (req),
        .update (arb_update),
        .grant  (arb_grant),
        .valid  (arb_valid)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state  <= IDLE;
            grant  <= 1'b0;
            htrans <= HTRANS_IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant  <= arb_grant;
                        state  <= ADDR;
                        htrans <= HTRANS_NONSEQ;
                    end
                end
                ADDR: begin
                    if (hready) begin
                        state  <= DATA;
                        htrans <= HTRANS_IDLE;
                    end
                end
                DATA: begin
                    if (hready)
                        state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    htrans <= HTRANS_IDLE;
                end
            endcase
        end
    end

    assign hburst = HBURST_SINGLE;
    assign haddr  = (state == ADDR) ? addr_v[grant]  : '0;
    assign hwrite = (state == ADDR) ? write_v[grant] : 1'b0;
    assign hsize  = (state == ADDR) ? size_v[grant]  : 3'b000;
    assign hwdata = (state == DATA) ? wdata_v[grant] : '0;

    // Completion is the data-phase hready; an ERROR's first cycle has hready low.
    assign done  = (state == DATA) && hready;
    assign ack   = done ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign rdata = done ? hrdata : '0;
    assign err   = done & hresp;

endmodule

// File: tb/tb_ahb_manager_arbiter.sv
// Directed bench for ahb_manager_arbiter: drives after posedge, samples at negedge.
module tb_ahb_manager_arbiter;

    logic        clk;
    logic        nrst;
    logic [1:0]  req;
    logic [31:0] addr0, addr1;
    logic        write0, write1;
    logic [2:0]  size0, size1;
    logic [31:0] wdata0, wdata1;
    logic [1:0]  ack;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    int checks;
    int failures;

    ahb_manager_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .nrst(nrst), .req(req),
        .addr0(addr0), .addr1(addr1), .write0(write0), .write1(write1),
        .size0(size0), .size1(size1), .wdata0(wdata0), .wdata1(wdata1),
        .ack(ack), .rdata(rdata), .err(err),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requesters must hold req until their ack (reset excepted).
    logic [1:0] pend;
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (nrst && pend[i])
                assert (req[i]) else $error("FAIL req_hold port%0d dropped before ack", i);
        end
        pend <= nrst ? (req & ~ack) : 2'b00;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic test_reset();
        nrst = 1'b0; req = 2'b00;
        addr0 = '0; addr1 = '0; write0 = 1'b0; write1 = 1'b0;
        size0 = 3'd0; size1 = 3'd0; wdata0 = '0; wdata1 = '0;
        hrdata = 32'h5555_AAAA; hready = 1'b1; hresp = 1'b0;
        nxt(); nxt();
        samp();
        checks++; if (htrans !== 2'b00) begin failures++; $display("FAIL reset_htrans got=%b exp=00", htrans); end
        checks++; if (ack !== 2'b00) begin failures++; $display("FAIL reset_ack got=%b exp=00", ack); end
        checks++; if (rdata !== 32'h0 || err !== 1'b0) begin failures++; $display("FAIL reset_rdata_err got=%h/%b exp=0/0", rdata, err); end
        checks++; if (haddr !== 32'h0 || hburst !== 3'b000) begin failures++; $display("FAIL reset_haddr_hburst got=%h/%b exp=0/000", haddr, hburst); end
        nxt(); nrst = 1'b1;
    endtask

    task automatic test_single_read();
        nxt();
        req = 2'b10; addr1 = 32'h2000_0010; write1 = 1'b0; size1 = 3'd2;
        hrdata = 32'hDEAD_BEEF; hready = 1'b1; hresp = 1'b0;
        samp();
        checks++; if (htrans !== 2'b00 || ack !== 2'b00) begin failures++; $display("FAIL rd_c0 got htrans=%b ack=%b exp=00/00", htrans, ack); end
        nxt(); samp();
        checks++; if (htrans !== 2'b10) begin failures++; $display("FAIL rd_c1_htrans got=%b exp=10", htrans); end
        checks++; if (haddr !== 32'h2000_0010 || hsize !== 3'd2 || hwrite !== 1'b0) begin failures++; $display("FAIL rd_c1_addr got=%h/%0d/%b exp=20000010/2/0", haddr, hsize, hwrite); end
        checks++; if (rdata !== 32'h0 || ack !== 2'b00) begin failures++; $display("FAIL rd_c1_noack got rdata=%h ack=%b exp=0/00", rdata, ack); end
        nxt(); samp();
        checks++; if (ack !== 2'b10) begin failures++; $display("FAIL rd_c2_ack got=%b exp=10", ack); end
        checks++; if (rdata !== 32'hDEAD_BEEF || err !== 1'b0) begin failures++; $display("FAIL rd_c2_data got=%h/%b exp=deadbeef/0", rdata, err); end
        checks++; if (htrans !== 2'b00 || haddr !== 32'h0) begin failures++; $display("FAIL rd_c2_bus got=%b/%h exp=00/0", htrans, haddr); end
        nxt(); req = 2'b00;
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_ack;
        logic [31:0] exp_addr;
        nxt();
        req = 2'b11; addr0 = 32'h1000_0000; addr1 = 32'h2000_0000;
        write0 = 1'b0; write1 = 1'b0; hrdata = 32'h0000_0001; hready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            // Port 0 stops after its last grant so nothing is left pending.
            if (t == 5) req = 2'b10;
            exp_ack  = (t % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (t % 2 == 0) ? 32'h1000_0000 : 32'h2000_0000;
            samp();
            checks++; if (htrans !== 2'b00) begin failures++; $display("FAIL rr_idle t=%0d got=%b exp=00", t, htrans); end
            nxt(); samp();
            checks++; if (htrans !== 2'b10 || haddr !== exp_addr) begin failures++; $display("FAIL rr_addr t=%0d got=%b/%h exp=10/%h", t, htrans, haddr, exp_addr); end
            nxt(); samp();
            checks++; if (ack !== exp_ack) begin failures++; $display("FAIL rr_ack t=%0d got=%b exp=%b", t, ack, exp_ack); end
            nxt();
        end
        req = 2'b00;
    endtask

    task automatic test_write_wait();
        nxt();
        req = 2'b01; addr0 = 32'h0000_0100; write0 = 1'b1; size0 = 3'd2;
        wdata0 = 32'h1234_5678; hready = 1'b1;
        samp();
        nxt(); samp();
        checks++; if (htrans !== 2'b10 || hwrite !== 1'b1 || haddr !== 32'h0000_0100) begin failures++; $display("FAIL wr_addr got=%b/%b/%h exp=10/1/00000100", htrans, hwrite, haddr); end
        nxt(); hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            samp();
            checks++; if (hwdata !== 32'h1234_5678 || ack !== 2'b00) begin failures++; $display("FAIL wr_wait%0d got hwdata=%h ack=%b exp=12345678/00", i, hwdata, ack); end
            nxt();
        end
        hready = 1'b1;
        samp();
        checks++; if (hwdata !== 32'h1234_5678 || ack !== 2'b01 || err !== 1'b0) begin failures++; $display("FAIL wr_done got hwdata=%h ack=%b err=%b exp=12345678/01/0", hwdata, ack, err); end
        nxt(); req = 2'b00; write0 = 1'b0;
        samp();
        checks++; if (hwdata !== 32'h0 || ack !== 2'b00) begin failures++; $display("FAIL wr_after got hwdata=%h ack=%b exp=0/00", hwdata, ack); end
    endtask

    task automatic test_addr_stall();
        nxt();
        req = 2'b10; addr1 = 32'h2000_0020; write1 = 1'b0; hready = 1'b1;
        hrdata = 32'hCAFE_0001;
        samp();
        nxt(); hready = 1'b0; samp();
        checks++; if (htrans !== 2'b10) begin failures++; $display("FAIL stall_c1 got=%b exp=10", htrans); end
        nxt(); hready = 1'b1; samp();
        checks++; if (htrans !== 2'b10 || haddr !== 32'h2000_0020 || ack !== 2'b00) begin failures++; $display("FAIL stall_c2 got=%b/%h/%b exp=10/20000020/00", htrans, haddr, ack); end
        nxt(); samp();
        checks++; if (ack !== 2'b10 || rdata !== 32'hCAFE_0001) begin failures++; $display("FAIL stall_c3 got ack=%b rdata=%h exp=10/cafe0001", ack, rdata); end
        nxt(); req = 2'b00;
    endtask

    task automatic test_unmapped_and_error();
        nxt();
        req = 2'b01; addr0 = 32'hF000_0000; write0 = 1'b0; hrdata = 32'h0;
        hready = 1'b1; hresp = 1'b0;
        samp();
        nxt(); samp();
        nxt(); samp();
        checks++; if (ack !== 2'b01 || rdata !== 32'h0 || err !== 1'b0) begin failures++; $display("FAIL unmap got ack=%b rdata=%h err=%b exp=01/0/0", ack, rdata, err); end
        nxt(); req = 2'b00;
        nxt();
        req = 2'b10; addr1 = 32'hF000_0004; write1 = 1'b0;
        samp();
        nxt(); samp();
        nxt(); hresp = 1'b1; hready = 1'b0; samp();
        checks++; if (ack !== 2'b00 || err !== 1'b0) begin failures++; $display("FAIL err_first got ack=%b err=%b exp=00/0", ack, err); end
        nxt(); hready = 1'b1; samp();
        checks++; if (ack !== 2'b10 || err !== 1'b1) begin failures++; $display("FAIL err_second got ack=%b err=%b exp=10/1", ack, err); end
        nxt(); req = 2'b00; hresp = 1'b0;
        samp();
        checks++; if (err !== 1'b0 || htrans !== 2'b00) begin failures++; $display("FAIL err_after got err=%b htrans=%b exp=0/00", err, htrans); end
    endtask

    task automatic test_reset_mid();
        nxt();
        req = 2'b01; addr0 = 32'h0000_0300; addr1 = 32'h2000_0300; hready = 1'b1;
        samp();
        nxt(); samp();
        nxt(); hready = 1'b0; samp();
        checks++; if (ack !== 2'b00) begin failures++; $display("FAIL rst_mid_wait got=%b exp=00", ack); end
        nrst = 1'b0; req = 2'b11;
        nxt(); nrst = 1'b1; hready = 1'b1; samp();
        checks++; if (htrans !== 2'b00 || ack !== 2'b00 || haddr !== 32'h0) begin failures++; $display("FAIL rst_mid_idle got htrans=%b ack=%b haddr=%h exp=00/00/0", htrans, ack, haddr); end
        nxt(); samp();
        checks++; if (htrans !== 2'b10 || haddr !== 32'h0000_0300) begin failures++; $display("FAIL rst_first_grant got=%b/%h exp=10/00000300", htrans, haddr); end
        nxt(); samp();
        checks++; if (ack !== 2'b01) begin failures++; $display("FAIL rst_first_ack got=%b exp=01", ack); end
        nxt(); req = 2'b10;
        samp();
        nxt(); samp();
        checks++; if (haddr !== 32'h2000_0300) begin failures++; $display("FAIL rst_second_grant got=%h exp=20000300", haddr); end
        nxt(); samp();
        checks++; if (ack !== 2'b10) begin failures++; $display("FAIL rst_second_ack got=%b exp=10", ack); end
        nxt(); req = 2'b00;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        pend = 2'b00;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_wait();
        test_addr_stall();
        test_unmapped_and_error();
        test_reset_mid();
        nxt(); nxt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
